// File: rtl/universal_shift_reg_if.sv
// Control, data and status bundle for universal_shift_reg.
// The tri-state Q view stays a plain module port so it can be resolved at the pin.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2:0]       mode;
    logic [WIDTH-1:0] data;
    logic             serialInLeft;
    logic             serialInRight;
    logic             outputEnable;
    logic             serialOutLeft;
    logic             serialOutRight;
    logic [CW-1:0]    shiftCount;
    logic             countDone;

    modport master (
        output mode, data, serialInLeft, serialInRight, outputEnable,
        input  serialOutLeft, serialOutRight, shiftCount, countDone
    );

    modport slave (
        input  mode, data, serialInLeft, serialInRight, outputEnable,
        output serialOutLeft, serialOutRight, shiftCount, countDone
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear with a saturating
// shift counter and a tri-state parallel view of the register.
module universal_shift_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    universal_shift_reg_if.slave bus,
    output logic [WIDTH-1:0]     Q
);
    localparam int            CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_CLR  = 3'b110,
        M_RSVD = 3'b111
    } mode_t;

    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             done;
    logic             bump;

    // Unmatched (including unknown) mode values fall to the default arm and hold.
    always_comb begin
        sreg_nxt = sreg;
        cnt_nxt  = cnt;
        bump     = 1'b0;
        case (bus.mode)
            M_LOAD: begin
                sreg_nxt = bus.data;
                cnt_nxt  = '0;
            end
            M_SHL: begin
                sreg_nxt = {sreg[WIDTH-2:0], bus.serialInRight};
                bump     = 1'b1;
            end
            M_SHR: begin
                sreg_nxt = {bus.serialInLeft, sreg[WIDTH-1:1]};
                bump     = 1'b1;
            end
            M_ROL: begin
                sreg_nxt = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
                bump     = 1'b1;
            end
            M_ROR: begin
                sreg_nxt = {sreg[0], sreg[WIDTH-1:1]};
                bump     = 1'b1;
            end
            M_CLR: begin
                sreg_nxt = '0;
                cnt_nxt  = '0;
            end
            M_HOLD, M_RSVD: ;
            default: ;
        endcase
        if (bump && (cnt != CNT_MAX))
            cnt_nxt = cnt + CW'(1);
    end

    // countDone is registered from the next count so it never sees input glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= RESET_VALUE;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            sreg <= sreg_nxt;
            cnt  <= cnt_nxt;
            done <= (cnt_nxt == CNT_MAX);
        end
    end

    assign Q                  = bus.outputEnable ? sreg : 'z;
    assign bus.serialOutLeft  = sreg[WIDTH-1];
    assign bus.serialOutRight = sreg[0];
    assign bus.shiftCount     = cnt;
    assign bus.countDone      = done;
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0: WIDTH-bit value loaded on reset.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port mode  input  3: operation select, sampled on rising clk.
REQ-006 Port data  input  WIDTH: parallel load value.
REQ-007 Port serialInLeft  input  1: bit entering the MSB on shift right.
REQ-008 Port serialInRight  input  1: bit entering the LSB on shift left.
REQ-009 Port outputEnable  input  1: 1 drives Q; 0 puts Q in high-Z.
REQ-010 Port Q  output  WIDTH: tri-state view of the internal register.
REQ-011 Port serialOutLeft  output  1: internal register MSB, never tri-stated.
REQ-012 Port serialOutRight  output  1: internal register LSB, never tri-stated.
REQ-013 Port shiftCount  output  $clog2(WIDTH)+1: shifts/rotates since last load or clear.
REQ-014 Port countDone  output  1: high when shiftCount equals WIDTH.

Function
REQ-015 mode 000 hold: register and shiftCount unchanged.
REQ-016 mode 001 load: register <= data; shiftCount <= 0.
REQ-017 mode 010 shift left: register <= {reg[WIDTH-2:0], serialInRight}.
REQ-018 mode 011 shift right: register <= {serialInLeft, reg[WIDTH-1:1]}.
REQ-019 mode 100 rotate left: register <= {reg[WIDTH-2:0], reg[WIDTH-1]}.
REQ-020 mode 101 rotate right: register <= {reg[0], reg[WIDTH-1:1]}.
REQ-021 mode 110 clear: register <= 0 (not RESET_VALUE); shiftCount <= 0.
REQ-022 mode 111 reserved: behaves exactly as hold.
REQ-023 Modes 010..101 increment shiftCount by 1, saturating at WIDTH; no wrap.
REQ-024 Latency: register, serial outputs, shiftCount and countDone reflect a mode one clock edge after sampling; no combinational path from mode/data to any output.
REQ-025 Q is combinational from register and outputEnable only: outputEnable=0 -> all WIDTH bits 'z' within the same delta, no clock needed.
REQ-026 outputEnable does not gate state: register and shiftCount keep updating while Q is high-Z; re-enabling shows current register value.
REQ-027 serialOutLeft/serialOutRight follow the register regardless of outputEnable.
REQ-028 countDone is a registered-state decode (shiftCount == WIDTH), glitch-free w.r.t. inputs.
REQ-029 Unknown (x) mode bits: treat as hold; state never corrupts to x from mode decode.

Reset
REQ-030 rst=1 immediately (no clock edge) sets register <= RESET_VALUE, shiftCount <= 0, countDone <= 0.
REQ-031 While rst=1, clock edges and mode are ignored; Q still obeys outputEnable.
REQ-032 Reset asserted mid-shift-sequence aborts it; first edge after rst falls executes the sampled mode from RESET_VALUE with count 0.

Verification (WIDTH=8, RESET_VALUE=0)
REQ-033 rst pulse between edges, outputEnable=1 -> Q=00000000 before next edge, shiftCount=0, countDone=0.
REQ-034 Load 0xA5, then 8 x shift left with serialInRight=1 -> Q sequence 4B,97,2F,5F,BF,7F,FF,FF; shiftCount 1..8; countDone=1 after 8th; 9th shift keeps shiftCount=8.
REQ-035 Load 0x81, rotate right x1 -> Q=0xC0, serialOutRight=0; rotate left x2 -> Q=0x03; shiftCount=3.
REQ-036 Load 0x3C, outputEnable=0 -> Q=zzzzzzzz, serialOutLeft=0; shift right with serialInLeft=1 -> outputEnable=1 shows Q=0x9E.
REQ-037 Load 0xFF, mode 110 -> Q=0x00, shiftCount=0; mode 111 for 3 edges -> Q=0x00, shiftCount=0.
REQ-038 Load 0x55, 3 shifts, assert rst mid-cycle -> Q=0x00, shiftCount=0 asynchronously; release, load 0x12 -> Q=0x12.
